// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - two-flop synchronized push-button debouncer with press/release strobes
// Optional feature macro: DEBOUNCE_RELEASE_PULSE_EN adds the release strobe port.
// The release strobe port is called release_pulse because "release" is a SystemVerilog keyword.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic out,
   output logic press
`ifdef DEBOUNCE_RELEASE_PULSE_EN
   ,
   output logic release_pulse
`endif
);

   typedef enum logic [1:0] {
      LOW_STABLE,
      WAIT_HIGH,
      HIGH_STABLE,
      WAIT_LOW
   } state_t;

   // Last counter value before a pending change is accepted.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             ff1;
   logic             ff2;
   logic             sync_in;
   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             out_nxt;
   logic             press_nxt;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
   logic             rel_nxt;
`endif

   assign sync_in = ff2;

   // Synchronizer, FSM state, counter and registered outputs; reset wins over everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         ff1   <= 1'b0;
         ff2   <= 1'b0;
         state <= LOW_STABLE;
         cnt   <= '0;
         out   <= 1'b0;
         press <= 1'b0;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
         release_pulse <= 1'b0;
`endif
      end else begin
         ff1   <= in;
         ff2   <= ff1;
         state <= state_nxt;
         cnt   <= cnt_nxt;
         out   <= out_nxt;
         press <= press_nxt;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
         release_pulse <= rel_nxt;
`endif
      end
   end

   // Next-state logic: a level must hold DEBOUNCE_CYCLES cycles in a WAIT state to be accepted.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      out_nxt   = out;
      press_nxt = 1'b0;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
      rel_nxt   = 1'b0;
`endif
      case (state)
         LOW_STABLE: begin
            if (sync_in) begin
               state_nxt = WAIT_HIGH;
               cnt_nxt   = '0;
            end
         end
         WAIT_HIGH: begin
            if (!sync_in) begin
               state_nxt = LOW_STABLE;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = HIGH_STABLE;
               cnt_nxt   = '0;
               out_nxt   = 1'b1;
               press_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         HIGH_STABLE: begin
            if (!sync_in) begin
               state_nxt = WAIT_LOW;
               cnt_nxt   = '0;
            end
         end
         WAIT_LOW: begin
            if (sync_in) begin
               state_nxt = HIGH_STABLE;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = LOW_STABLE;
               cnt_nxt   = '0;
               out_nxt   = 1'b0;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
               rel_nxt   = 1'b1;
`endif
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = LOW_STABLE;
            cnt_nxt   = '0;
            out_nxt   = 1'b0;
         end
      endcase
   end

endmodule

// File: doc/button_debouncer.md
BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, number of consecutive stable clk cycles required to accept a level change (10 ms at 100 MHz); legal range >= 2.
REQ-002 Parameter CNT_W, default 20, stability counter width; SHALL satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 clk  input  1  system clock, 100 MHz board oscillator; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 in  input  1  raw asynchronous push-button level, bouncing.
REQ-006 out  output  1  debounced, registered button level; feeds the downstream pulse/edge FSM.
REQ-007 press  output  1  single-cycle registered strobe on accepted 0->1 change.
REQ-008 release  output  1  single-cycle registered strobe on accepted 1->0 change (present only per REQ-024).

Function
REQ-009 in SHALL pass through a two-flop synchronizer (ff1, ff2) before any other logic; ff2 output is sync_in.
REQ-010 Control FSM SHALL have exactly four states: LOW_STABLE, WAIT_HIGH, HIGH_STABLE, WAIT_LOW.
REQ-011 LOW_STABLE: sync_in=1 -> WAIT_HIGH with counter cleared to 0; else remain.
REQ-012 WAIT_HIGH: sync_in=0 -> LOW_STABLE, counter cleared, no output change; sync_in=1 and counter < DEBOUNCE_CYCLES-1 -> counter+1; sync_in=1 and counter = DEBOUNCE_CYCLES-1 -> HIGH_STABLE, out<=1, press<=1 for one cycle, counter cleared.
REQ-013 HIGH_STABLE / WAIT_LOW SHALL mirror REQ-011/REQ-012 with polarity inverted; acceptance sets out<=0 and pulses release (if compiled in).
REQ-014 Latency: with in held constant after a change, out SHALL change on the (DEBOUNCE_CYCLES+3)th rising clk edge, counting the first edge at which ff1 samples the new level.
REQ-015 Any sync_in reversal before acceptance SHALL abort the pending change; glitches shorter than DEBOUNCE_CYCLES cycles SHALL never change out or produce strobes.
REQ-016 press and release SHALL each be high for exactly one clk cycle per accepted change and SHALL never be high simultaneously.
REQ-017 out SHALL be driven only from a flop; no combinational path from in to any output.
REQ-018 Counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-019 out SHALL equal 1 exactly in HIGH_STABLE and WAIT_LOW, and 0 in LOW_STABLE and WAIT_HIGH.

Reset
REQ-020 rst=1 at a rising edge SHALL force: ff1=0, ff2=0, state=LOW_STABLE, counter=0, out=0, press=0, release=0.
REQ-021 rst asserted mid-debounce (WAIT_HIGH/WAIT_LOW) SHALL discard the pending change with no strobe emitted.
REQ-022 After rst deasserts, a held-high in SHALL be treated as a new 0->1 change and accepted per REQ-014, producing one press.
REQ-023 rst SHALL take priority over all other conditions in the same cycle.

Configuration
REQ-024 Macro DEBOUNCE_RELEASE_PULSE_EN: defined -> release port and its logic present per REQ-013/REQ-016; undefined -> release port absent, press and out behaviour bit-identical to defined build.

Verification (DEBOUNCE_CYCLES=4 for bench)
REQ-025 rst=1 two cycles, in=1 -> out=0, press=0, release=0 throughout reset.
REQ-026 Clean press: in 0->1 held -> out=1 on 7th edge after first ff1 sample of 1; press=1 that cycle only.
REQ-027 Bounce: in toggles 1,0,1,0 each cycle for 8 cycles then held 1 -> exactly one press, out rises 7 edges after final stable 1 sampled.
REQ-028 Glitch: in=1 for 3 cycles in LOW_STABLE -> out stays 0, no press.
REQ-029 Release with DEBOUNCE_RELEASE_PULSE_EN defined: from out=1, in->0 held -> out=0 on 7th edge, release=1 one cycle; rebuilt undefined -> no release port, out timing identical.
REQ-030 Reset mid-operation: rst=1 asserted during WAIT_HIGH (counter=2), in stays 1 -> no press during reset; after rst=0, press occurs 7 edges later.
